hs_npu_stream_packer: RTL and testbench
=======================================

# hs_npu_stream_packer

Transmit-side companion to the NPU handshake FIFOs: accepts a stream of narrow elements over ready/valid, packs LANES consecutive elements into one wide word, and drives that word toward a FIFO's write port under the same ready/valid protocol. It sits between element producers (activation/weight unpackers, result serializers) and the `hs_npu_fifo` instances that buffer full-width words for the systolic array. A short burst can be closed early with `elem_last`, producing a zero-padded partial word with a lane mask.

## Interface
- ELEM_WIDTH, 8, bits per element
- LANES, 4, elements per output word (≥2)
- COUNT_WIDTH, 16, width of the transmitted-word counter
- clk_core  in  1  core clock
- rst_core_n  in  1  reset; one clock, asynchronous and active-low
- flush  in  1  synchronous clear of packing state, output slot and counter
- elem_valid_i  in  1  element present
- elem_ready_o  out  1  element accepted this cycle when high with elem_valid_i
- elem_i  in  ELEM_WIDTH  element data
- elem_last_i  in  1  element closes current word (and burst)
- word_ready_i  in  1  downstream (FIFO) can take word
- word_valid_o  out  1  word slot holds a word
- word_o  out  ELEM_WIDTH*LANES  packed word
- word_mask_o  out  LANES  bit k set = lane k holds a real element
- word_last_o  out  1  word was closed by elem_last_i
- word_count_o  out  COUNT_WIDTH  number of word handshakes since reset/flush, wraps

## Operation
- State: pack register (LANES lanes), lane index `lane` (0..LANES-1), pack mask, one output slot (word/mask/last/valid), counter.
- Element handshake = elem_valid_i & elem_ready_o; element written to lane `lane`, bits [lane*ELEM_WIDTH +: ELEM_WIDTH]; mask bit `lane` set.
- Word closes on accepted element when lane == LANES-1 or elem_last_i = 1.
- On close: output slot loads packed word (current element merged in), mask, last = elem_last_i; valid_o ← 1; pack register, mask and lane clear to 0. Unfilled lanes are zero.
- No close: lane ← lane+1.
- out_free = ~word_valid_o | word_ready_i.
- elem_ready_o = out_free | (lane != LANES-1 & ~elem_last_i). Depends combinationally on elem_last_i, never on elem_valid_i.
- Word handshake = word_valid_o & word_ready_i; valid_o ← 0 unless a close loads a new word in the same cycle (then stays 1, new data). word_count_o increments by 1 per handshake, mod 2^COUNT_WIDTH.
- Stall (valid_o & ~word_ready_i): word_o, word_mask_o, word_last_o held stable; valid_o never deasserts without a handshake (except flush/reset).
- elem_last_i with lane == 0: single-element word, mask = 0…01.
- flush: lane, pack register, mask, output slot valid and counter cleared at the edge; dominates any same-cycle element or word handshake (neither takes effect, count not incremented). elem_ready_o not gated by flush.
- Reset (asynchronous, any time, including mid-word): all state to 0; partial word discarded.

## Timing
- Reset values: elem_ready_o = 1 (lane 0, slot empty), word_valid_o = 0, word_o = 0, word_mask_o = 0, word_last_o = 0, word_count_o = 0.
- Latency: closing element accepted at edge N → word_valid_o high after edge N (visible cycle N+1).
- Throughput: one element per cycle sustained with word_ready_i held high; one word every LANES cycles; no bubbles between words.
- Backpressure: with slot full and word_ready_i low, lanes 0..LANES-2 still accept; elem_ready_o drops only for a closing element.
- word_count_o updates the cycle after the handshake edge (registered).

## Test plan
- Full word, LANES=4, ELEM_WIDTH=8: elements 0x11,0x22,0x33,0x44 back-to-back, ready high → one cycle after 4th accept word_o = 0x44332211, mask 0xF, last 0, count 0→1.
- Partial: 0xAA, 0xBB(last) → word_o = 0x0000BBAA, mask 0x3, last 1; next element lands in lane 0.
- Backpressure: word_ready_i low, stream 8 elements → first word held stable; elements 5–7 accepted, element 8 stalled (elem_ready_o = 0) until word_ready_i rises; then both words delivered in order, count = 2.
- Throughput: 12 elements, ready high → 3 words on consecutive 4-cycle boundaries, no gaps in elem_ready_o.
- Flush: 2 elements packed and a word pending, assert flush with elem_valid_i and word_ready_i high → next cycle word_valid_o = 0, count = 0, lane 0; following 4 elements produce a word with no stale lanes.
- Reset mid-word and counter wrap (COUNT_WIDTH=2): async reset after 3 elements → all outputs reset immediately; 5 subsequent words → count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/hs_npu_stream_packer.sv
// Packs LANES narrow elements into one wide word; the word is valid one cycle after its closing element is accepted.
// Backpressure: while the output slot is full and not draining, only an element that would close a word is stalled.
module hs_npu_stream_packer #(
  parameter int ELEM_WIDTH  = 8,
  parameter int LANES       = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                        clk_core,
  input  logic                        rst_core_n,
  input  logic                        flush,
  input  logic                        elem_valid_i,
  output logic                        elem_ready_o,
  input  logic [ELEM_WIDTH-1:0]       elem_i,
  input  logic                        elem_last_i,
  input  logic                        word_ready_i,
  output logic                        word_valid_o,
  output logic [ELEM_WIDTH*LANES-1:0] word_o,
  output logic [LANES-1:0]            word_mask_o,
  output logic                        word_last_o,
  output logic [COUNT_WIDTH-1:0]      word_count_o
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WW = ELEM_WIDTH * LANES;
  localparam logic [LW-1:0] LANE_MAX = LW'(LANES - 1);

  logic [WW-1:0]          pack_q;
  logic [WW-1:0]          pack_merged;
  logic [LANES-1:0]       pmask_q;
  logic [LANES-1:0]       pmask_merged;
  logic [LW-1:0]          lane_q;
  logic [WW-1:0]          word_q;
  logic [LANES-1:0]       wmask_q;
  logic                   wlast_q;
  logic                   wvalid_q;
  logic [COUNT_WIDTH-1:0] count_q;

  logic out_free;
  logic lane_at_end;
  logic elem_hs;
  logic word_hs;
  logic close;

  always_comb begin
    out_free     = ~wvalid_q | word_ready_i;
    lane_at_end  = (lane_q == LANE_MAX);
    // Only a closing element needs the slot, so non-closing lanes keep flowing under backpressure.
    elem_ready_o = out_free | (~lane_at_end & ~elem_last_i);
    elem_hs      = elem_valid_i & elem_ready_o;
    word_hs      = wvalid_q & word_ready_i;
    close        = elem_hs & (lane_at_end | elem_last_i);
  end

  always_comb begin
    pack_merged  = pack_q;
    pmask_merged = pmask_q;
    for (int k = 0; k < LANES; k++) begin
      if (lane_q == LW'(k)) begin
        pack_merged[k*ELEM_WIDTH +: ELEM_WIDTH] = elem_i;
        pmask_merged[k]                         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      pack_q  <= '0;
      pmask_q <= '0;
      lane_q  <= '0;
    end else if (flush) begin
      pack_q  <= '0;
      pmask_q <= '0;
      lane_q  <= '0;
    end else if (elem_hs) begin
      if (close) begin
        pack_q  <= '0;
        pmask_q <= '0;
        lane_q  <= '0;
      end else begin
        pack_q  <= pack_merged;
        pmask_q <= pmask_merged;
        lane_q  <= lane_q + LW'(1);
      end
    end
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      word_q   <= '0;
      wmask_q  <= '0;
      wlast_q  <= 1'b0;
      wvalid_q <= 1'b0;
    end else if (flush) begin
      word_q   <= '0;
      wmask_q  <= '0;
      wlast_q  <= 1'b0;
      wvalid_q <= 1'b0;
    end else if (close) begin
      // A close can only happen when the slot is free, so this never overwrites an undelivered word.
      word_q   <= pack_merged;
      wmask_q  <= pmask_merged;
      wlast_q  <= elem_last_i;
      wvalid_q <= 1'b1;
    end else if (word_hs) begin
      wvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else if (word_hs) begin
      count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

  assign word_valid_o = wvalid_q;
  assign word_o       = word_q;
  assign word_mask_o  = wmask_q;
  assign word_last_o  = wlast_q;
  assign word_count_o = count_q;

endmodule

// File: tb/tb_hs_npu_stream_packer.sv
// Randomised and directed bench for hs_npu_stream_packer, checked every cycle against an element-queue model.
module tb_hs_npu_stream_packer;

  localparam int EW = 8;
  localparam int LN = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          elem_valid = 1'b0;
  logic          elem_ready;
  logic [EW-1:0] elem = '0;
  logic          elem_last = 1'b0;
  logic          word_ready = 1'b0;
  logic          word_valid;
  logic [EW*LN-1:0] word;
  logic [LN-1:0] word_mask;
  logic          word_last;
  logic [CW-1:0] word_count;

  int vectors = 0;
  int fails = 0;
  int cyc = 0;

  hs_npu_stream_packer #(.ELEM_WIDTH(EW), .LANES(LN), .COUNT_WIDTH(CW)) dut (
    .clk_core(clk), .rst_core_n(rst_n), .flush(flush),
    .elem_valid_i(elem_valid), .elem_ready_o(elem_ready), .elem_i(elem), .elem_last_i(elem_last),
    .word_ready_i(word_ready), .word_valid_o(word_valid), .word_o(word), .word_mask_o(word_mask),
    .word_last_o(word_last), .word_count_o(word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: elements of the open word, and words closed but not yet taken downstream.
  typedef struct {
    logic [EW*LN-1:0] w;
    logic [LN-1:0]    m;
    logic             l;
  } wd_t;

  logic [EW-1:0] pend[$];
  wd_t           exp_q[$];
  int            mcnt = 0;

  always @(negedge clk) begin
    bit  m_ready;
    wd_t nw;
    if (!rst_n) begin
      pend.delete();
      exp_q.delete();
      mcnt = 0;
      chk("rst_word_valid", {63'b0, word_valid}, 64'd0);
      chk("rst_word_count", {62'b0, word_count}, 64'd0);
      chk("rst_elem_ready", {63'b0, elem_ready}, 64'd1);
    end else begin
      chk("word_valid", {63'b0, word_valid}, {63'b0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        chk("word", {32'b0, word}, {32'b0, exp_q[0].w});
        chk("word_mask", {60'b0, word_mask}, {60'b0, exp_q[0].m});
        chk("word_last", {63'b0, word_last}, {63'b0, exp_q[0].l});
      end
      chk("word_count", {62'b0, word_count}, 64'(mcnt));
      m_ready = (exp_q.size() == 0) || word_ready || ((pend.size() != LN - 1) && !elem_last);
      chk("elem_ready", {63'b0, elem_ready}, {63'b0, m_ready});
      if (flush) begin
        pend.delete();
        exp_q.delete();
        mcnt = 0;
      end else begin
        if (exp_q.size() != 0 && word_ready) begin
          void'(exp_q.pop_front());
          mcnt = (mcnt + 1) % (1 << CW);
        end
        if (elem_valid && m_ready) begin
          pend.push_back(elem);
          if (pend.size() == LN || elem_last) begin
            nw.w = '0;
            for (int k = 0; k < pend.size(); k++) nw.w = nw.w | ((EW*LN)'(pend[k]) << (EW * k));
            nw.m = LN'((1 << pend.size()) - 1);
            nw.l = elem_last;
            exp_q.push_back(nw);
            pend.delete();
          end
        end
        if (exp_q.size() > 1) begin
          vectors++;
          fails++;
          $display("FAIL slot_overrun: %0d words pending, expected at most 1", exp_q.size());
        end
      end
    end
  end

  task automatic send(input logic [EW-1:0] d, input logic l);
    int budget = 200;
    elem_valid = 1'b1;
    elem = d;
    elem_last = l;
    @(negedge clk);
    while (!elem_ready && budget > 0) begin
      budget--;
      @(negedge clk);
    end
    if (budget == 0) begin
      vectors++;
      fails++;
      $display("FAIL send_timeout: elem_ready stayed 0, expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    elem_valid = 1'b0;
    elem_last = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    int t0;
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int t0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_rst_count", {62'b0, word_count}, 64'd0);
    chk("post_rst_ready", {63'b0, elem_ready}, 64'd1);

    // Full word
    word_ready = 1'b1;
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    chk("full_word", {32'b0, word}, 64'h44332211);
    chk("full_mask", {60'b0, word_mask}, 64'hF);
    chk("full_last", {63'b0, word_last}, 64'd0);
    chk("full_count0", {62'b0, word_count}, 64'd0);
    tick();
    chk("full_count1", {62'b0, word_count}, 64'd1);

    // Partial word, then single-element word from lane 0
    send(8'hAA, 1'b0); send(8'hBB, 1'b1);
    chk("part_word", {32'b0, word}, 64'h0000BBAA);
    chk("part_mask", {60'b0, word_mask}, 64'h3);
    chk("part_last", {63'b0, word_last}, 64'd1);
    send(8'hCC, 1'b1);
    chk("single_word", {32'b0, word}, 64'h000000CC);
    chk("single_mask", {60'b0, word_mask}, 64'h1);
    tick();

    // Backpressure
    word_ready = 1'b0;
    c0 = int'(word_count);
    for (int i = 1; i <= 7; i++) send(8'(i), 1'b0);
    elem_valid = 1'b1; elem = 8'h08;
    repeat (3) @(negedge clk);
    chk("bp_stall_ready", {63'b0, elem_ready}, 64'd0);
    chk("bp_held_word", {32'b0, word}, 64'h04030201);
    chk("bp_held_valid", {63'b0, word_valid}, 64'd1);
    @(posedge clk); #1;
    word_ready = 1'b1;
    send(8'h08, 1'b0);
    tick();
    chk("bp_count_delta", 64'((int'(word_count) - c0) & 3), 64'd2);

    // Throughput: 12 elements in 12 cycles
    t0 = cyc;
    for (int i = 0; i < 12; i++) send(8'(8'h60 + i), 1'b0);
    chk("thru_cycles", 64'(cyc - t0), 64'd12);
    tick();

    // Flush dominates same-cycle handshakes
    word_ready = 1'b0;
    send(8'h51, 1'b0); send(8'h52, 1'b0); send(8'h53, 1'b0); send(8'h54, 1'b0);
    send(8'h55, 1'b0); send(8'h56, 1'b0);
    flush = 1'b1; elem_valid = 1'b1; elem = 8'h99; word_ready = 1'b1;
    tick();
    flush = 1'b0; elem_valid = 1'b0;
    chk("flush_valid", {63'b0, word_valid}, 64'd0);
    chk("flush_count", {62'b0, word_count}, 64'd0);
    send(8'hE1, 1'b0); send(8'hE2, 1'b0); send(8'hE3, 1'b0); send(8'hE4, 1'b0);
    chk("flush_word", {32'b0, word}, 64'hE4E3E2E1);
    chk("flush_mask", {60'b0, word_mask}, 64'hF);
    tick();

    // Async reset mid-word, then counter wrap
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'b0, word_valid}, 64'd0);
    chk("arst_word", {32'b0, word}, 64'd0);
    chk("arst_mask", {60'b0, word_mask}, 64'd0);
    chk("arst_count", {62'b0, word_count}, 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      for (int k = 0; k < LN; k++) send(8'(16 * i + k), 1'b0);
      tick();
      chk("wrap_count", {62'b0, word_count}, 64'(i % 4));
    end

    // Random traffic with varying downstream pressure
    for (int ph = 0; ph < 4; ph++) begin
      repeat (800) begin
        @(posedge clk); #1;
        elem_valid = ($urandom % 4) != 0;
        elem       = 8'($urandom);
        elem_last  = ($urandom % 6) == 0;
        word_ready = ($urandom % 4) < ph + 1;
        flush      = ($urandom % 150) == 0;
      end
    end
    @(posedge clk); #1;
    elem_valid = 1'b0; elem_last = 1'b0; flush = 1'b0; word_ready = 1'b1;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
